// File: rtl/demux1_to_2_32bit_pipe_if.sv
// Valid/ready bundle for the 1-to-2 demux: one upstream port, two downstream
// ports and the per-channel occupancy taps.
interface demux1_to_2_32bit_pipe_if #(
  parameter int bit_width = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [bit_width-1:0] in_data;
  logic                 select;

  logic                 out0_valid;
  logic                 out0_ready;
  logic [bit_width-1:0] out0_data;

  logic                 out1_valid;
  logic                 out1_ready;
  logic [bit_width-1:0] out1_data;

  logic [1:0]           count0;
  logic [1:0]           count1;

  // Environment side: produces words and consumes both channels.
  modport master (
    output in_valid, in_data, select, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data,
           count0, count1
  );

  // Demux side.
  modport slave (
    input  in_valid, in_data, select, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data,
           count0, count1
  );
endinterface

// File: rtl/demux1_to_2_32bit_pipe.sv
// Registered 1-to-2 demultiplexer. Each channel owns a 2-entry FIFO so a
// stalled consumer only blocks words addressed to it. The FIFO head is kept
// in its own reset register so outN_data is 0 whenever the channel is empty
// and comes straight from a flop.
module demux1_to_2_32bit_pipe #(
  parameter int bit_width = 32
) (
  input logic                     clk,
  input logic                     rst_n,
  demux1_to_2_32bit_pipe_if.slave bus
);

  logic [1:0]           count  [2];
  logic [1:0]           rd_ptr;
  logic [1:0]           wr_ptr;
  logic [bit_width-1:0] mem    [2][2];
  logic [bit_width-1:0] head   [2];

  logic       accept;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_ready;

  // in_ready looks only at registered occupancy, never at the consumer ready.
  assign bus.in_ready = ((bus.select ? count[1] : count[0]) != 2'd2);
  assign accept       = bus.in_valid & bus.in_ready;
  assign push[0]      = accept & ~bus.select;
  assign push[1]      = accept &  bus.select;

  assign out_ready[0] = bus.out0_ready;
  assign out_ready[1] = bus.out1_ready;
  assign pop[0]       = (count[0] != 2'd0) & out_ready[0];
  assign pop[1]       = (count[1] != 2'd0) & out_ready[1];

  assign bus.out0_valid = (count[0] != 2'd0);
  assign bus.out1_valid = (count[1] != 2'd0);
  assign bus.out0_data  = head[0];
  assign bus.out1_data  = head[1];
  assign bus.count0     = count[0];
  assign bus.count1     = count[1];

  // FIFO storage; contents are meaningless until counted, so no reset.
  always_ff @(posedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (push[ch]) mem[ch][wr_ptr[ch]] <= bus.in_data;
    end
  end

  // Occupancy, pointers and the registered head word per channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int ch = 0; ch < 2; ch++) begin
        count[ch] <= 2'd0;
        head[ch]  <= '0;
      end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        case ({push[ch], pop[ch]})
          2'b10: begin
            count[ch]  <= count[ch] + 2'd1;
            wr_ptr[ch] <= ~wr_ptr[ch];
          end
          2'b01: begin
            count[ch]  <= count[ch] - 2'd1;
            rd_ptr[ch] <= ~rd_ptr[ch];
          end
          2'b11: begin
            wr_ptr[ch] <= ~wr_ptr[ch];
            rd_ptr[ch] <= ~rd_ptr[ch];
          end
          default: ;
        endcase

        // Head tracks what will sit at rd_ptr after this edge; a push into a
        // FIFO that is (or becomes) empty bypasses storage.
        if (pop[ch]) begin
          if (count[ch] == 2'd2)  head[ch] <= mem[ch][~rd_ptr[ch]];
          else if (push[ch])      head[ch] <= bus.in_data;
          else                    head[ch] <= '0;
        end else if (push[ch] && count[ch] == 2'd0) begin
          head[ch] <= bus.in_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_demux1_to_2_32bit_pipe.sv
// Bench for demux1_to_2_32bit_pipe: a table of hand-derived vectors plus
// multi-cycle sequences, all cross-checked by per-channel reference queues.
module tb_demux1_to_2_32bit_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  demux1_to_2_32bit_pipe_if #(.bit_width(32)) bus ();

  demux1_to_2_32bit_pipe #(.bit_width(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  typedef struct {
    logic        v;
    logic        sel;
    logic [31:0] d;
    logic        r0;
    logic        r1;
    logic        exp_rdy;
    logic [1:0]  exp_c0;
    logic [1:0]  exp_c1;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] head_of(input int ch);
    if (ch == 0) return (q0.size() != 0) ? q0[0] : 32'd0;
    else         return (q1.size() != 0) ? q1[0] : 32'd0;
  endfunction

  task automatic check_outputs(input logic sel);
    int n_sel;
    n_sel = sel ? q1.size() : q0.size();
    check("in_ready",   {31'd0, bus.in_ready},   {31'd0, n_sel != 2});
    check("out0_valid", {31'd0, bus.out0_valid}, {31'd0, q0.size() != 0});
    check("out1_valid", {31'd0, bus.out1_valid}, {31'd0, q1.size() != 0});
    check("count0",     {30'd0, bus.count0},     32'(q0.size()));
    check("count1",     {30'd0, bus.count1},     32'(q1.size()));
    check("out0_data",  bus.out0_data,           head_of(0));
    check("out1_data",  bus.out1_data,           head_of(1));
  endtask

  // Called just after a negedge; drives one cycle and returns after the next negedge.
  task automatic step(input logic v, input logic sel, input logic [31:0] d,
                      input logic r0, input logic r1);
    logic exp_rdy;
    bus.in_valid   = v;
    bus.select     = sel;
    bus.in_data    = d;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
    #1;
    exp_rdy = sel ? (q1.size() != 2) : (q0.size() != 2);
    check_outputs(sel);
    if (r0 && q0.size() != 0) void'(q0.pop_front());
    if (r1 && q1.size() != 0) void'(q1.pop_front());
    if (v && exp_rdy) begin
      if (sel) q1.push_back(d);
      else     q0.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.select     = 1'b0;
    bus.in_data    = 32'd0;
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;

    // Reset state while rst_n is low from time zero.
    #3;
    check_outputs(1'b0);
    check_outputs(1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic routing, then fill/backpressure on channel 0.
    //            v    sel   data          r0   r1   rdy  c0    c1
    vecs[0]  = '{1'b1, 1'b0, 32'hA5A5_0001, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0};
    vecs[1]  = '{1'b1, 1'b1, 32'h5A5A_0002, 1'b1, 1'b1, 1'b1, 2'd1, 2'd0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 2'd0, 2'd1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 2'd0, 2'd0};
    vecs[4]  = '{1'b1, 1'b0, 32'h11,        1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
    vecs[5]  = '{1'b1, 1'b0, 32'h22,        1'b0, 1'b1, 1'b1, 2'd1, 2'd0};
    vecs[6]  = '{1'b1, 1'b0, 32'h33,        1'b0, 1'b1, 1'b0, 2'd2, 2'd0};
    vecs[7]  = '{1'b1, 1'b0, 32'h33,        1'b1, 1'b1, 1'b0, 2'd2, 2'd0};
    vecs[8]  = '{1'b1, 1'b0, 32'h33,        1'b1, 1'b1, 1'b1, 2'd1, 2'd0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 2'd1, 2'd0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 2'd0, 2'd0};

    for (int i = 0; i < 11; i++) begin
      bus.in_valid   = vecs[i].v;
      bus.select     = vecs[i].sel;
      bus.in_data    = vecs[i].d;
      bus.out0_ready = vecs[i].r0;
      bus.out1_ready = vecs[i].r1;
      #1;
      check($sformatf("vec%0d_rdy", i), {31'd0, bus.in_ready}, {31'd0, vecs[i].exp_rdy});
      check($sformatf("vec%0d_c0", i),  {30'd0, bus.count0},   {30'd0, vecs[i].exp_c0});
      check($sformatf("vec%0d_c1", i),  {30'd0, bus.count1},   {30'd0, vecs[i].exp_c1});
      step(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].r0, vecs[i].r1);
    end

    // Isolation: channel 0 full and stalled, channel 1 streams at full rate.
    step(1'b1, 1'b0, 32'h44, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'h55, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      bus.select = 1'b1;
      #1;
      check("iso_ready", {31'd0, bus.in_ready}, 32'd1);
      step(1'b1, 1'b1, 32'hC000_0000 + 32'(i), 1'b0, 1'b1);
    end
    check("iso_count0", {30'd0, bus.count0}, 32'd2);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Simultaneous push/pop on channel 1 with count held at 1; pointers wrap.
    step(1'b1, 1'b1, 32'hD000_00FF, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 32'hD000_0000 + 32'(i * 3), 1'b1, 1'b1);
      check("pp_count1", {30'd0, bus.count1}, 32'd1);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Reset mid-stream with count0 = 2 and count1 = 1.
    step(1'b1, 1'b0, 32'hE000_0001, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'hE000_0002, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'hE000_0003, 1'b0, 1'b0);
    check("pre_rst_c0", {30'd0, bus.count0}, 32'd2);
    check("pre_rst_c1", {30'd0, bus.count1}, 32'd1);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    check_outputs(1'b0);
    check_outputs(1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 32'hF00D_0001, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'hF00D_0002, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    check("final_q0_empty", 32'(q0.size()), 32'd0);
    check("final_q1_empty", 32'(q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/demux1_to_2_32bit_pipe.md
# demux1_to_2_32bit_pipe

Registered 1-to-2 demultiplexer that steers a stream of 32-bit words to one of two downstream consumers under a per-word select bit, the inverse of the 2-to-1 datapath muxes in the pipeline. Each destination has its own 2-entry FIFO, so a stalled consumer blocks only words addressed to it. Typical placement: issue/dispatch stage routing operands to the ALU path (channel 0) or the multi-cycle multiply/divide path (channel 1).

## Interface
- bit_width, 32: data word width.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  bit_width  upstream word.
- select  input  1  destination: 0 = channel 0, 1 = channel 1; sampled only with in_valid.
- out0_valid  output  1  channel 0 FIFO head valid.
- out0_ready  input  1  channel 0 consumer takes the head.
- out0_data  output  bit_width  channel 0 FIFO head.
- out1_valid, out1_ready, out1_data: same as channel 0, for channel 1.
- count0, count1  output  2 each  current FIFO occupancy (0..2).

## Operation
- Accept: accept = in_valid & in_ready. The word is written to the FIFO for channel select.
- in_ready = (select ? count1 : count0) != 2. It depends only on registered occupancy and select, never on out*_ready, so there is no ready-to-ready combinational path.
- Pop on channel n: outn_valid & outn_ready. outn_valid = (countn != 0). outn_data = head entry, driven from a register and stable while outn_valid & !outn_ready.
- Per-channel FIFO: 2 entries, a 1-bit read pointer, a 1-bit write pointer, and a 2-bit count. Pointers wrap 1 -> 0.
  - Push only: count +1.
  - Pop only: count -1.
  - Push and pop in the same cycle (count 1 or 2 before; count 2 cannot push): count unchanged, both pointers advance.
- Ordering: within a channel, words leave in acceptance order. There is no ordering relation between channels.
- select and in_data are don't-care when in_valid = 0. Upstream must hold in_data and select stable while in_valid & !in_ready, as in a standard valid/ready source.
- Both channels pop independently in the same cycle.

## Timing
- Latency: a word accepted at edge k is visible on outn_data/outn_valid after edge k, i.e. one cycle, when the FIFO was empty.
- Full condition: with count = 2, in_ready stays low in the cycle the consumer pops. in_ready rises in the following cycle, so the steady-state throughput into one channel with an always-ready consumer is 1 word/cycle.
- Reset: asynchronous assert on rst_n falling. While low and after release:
  - count0 = count1 = 0, pointers = 0.
  - out0_valid = out1_valid = 0, out0_data = out1_data = 0.
  - in_ready = 1.
- Reset mid-operation discards all buffered words; nothing is delivered after release. Release is synchronous to clk in the surrounding design.
- FIFO storage registers may be left without reset, but outn_data must read 0 whenever countn = 0 after reset. The head register is reset.

## Test plan
- Reset: drive rst_n = 0 asynchronously mid-cycle -> count0 = count1 = 0, out0_valid = out1_valid = 0, in_ready = 1 immediately, without waiting for a clock edge.
- Basic routing: both consumers ready; send 0xA5A5_0001 with select = 0, then 0x5A5A_0002 with select = 1 -> 0xA5A5_0001 appears on channel 0 one cycle after acceptance, 0x5A5A_0002 appears on channel 1 one cycle later; no word appears on the wrong channel.
- Fill/backpressure: out0_ready = 0; send 0x11, 0x22, 0x33 to channel 0.
  - count0 reaches 2 and in_ready drops while select = 0.
  - Raise out0_ready -> 0x11 then 0x22 pop, and 0x33 is accepted one cycle after the first pop.
- Isolation: channel 0 full and stalled -> words with select = 1 are still accepted at 1 word/cycle and delivered on channel 1.
- Simultaneous push/pop: count1 = 1 and out1_ready = 1 while pushing to channel 1 every cycle for 8 cycles -> count1 stays 1 and the output sequence equals the input sequence, covering pointer wrap.
- Reset mid-stream: reset with count0 = 2 and count1 = 1 -> after release there is no outn_valid until new words arrive, and the first new word emerges correctly.
